// File: rtl/mem_tap_pkg.sv
// mem_tap_pkg: shared types and constants for the mem_snapshot_tap slice.
// Contents: tap FSM state enum, default parameter values, and the helper
// that gives the position of entry i within the flattened tap bus.
package mem_tap_pkg;

    typedef enum logic [1:0] {
        TAP_IDLE    = 2'd0,
        TAP_CAPTURE = 2'd1,
        TAP_STREAM  = 2'd2
    } tap_state_e;

    localparam int DEF_NUM_ENTRIES = 32;
    localparam int DEF_ENTRY_W     = 33;
    localparam int DEF_DROP_CNT_W  = 8;

    // Lowest bit of entry idx in a bus of w-bit entries packed from bit 0 upward;
    // slice with bus[entry_lsb(i, w) +: w].
    function automatic int entry_lsb(input int idx, input int w);
        return idx * w;
    endfunction

endpackage

// File: rtl/mem_snapshot_tap_if.sv
// mem_snapshot_tap_if: snapshot beat stream, one captured entry per beat.
// Latency: n/a (wires only). Backpressure: producer holds a beat while out_ready=0.
// Signals: out_valid/out_index/out_data/out_last from producer, out_ready from consumer.
interface mem_snapshot_tap_if #(
    parameter int IDX_W   = 5,
    parameter int ENTRY_W = mem_tap_pkg::DEF_ENTRY_W
);
    logic               out_valid;
    logic               out_ready;
    logic [IDX_W-1:0]   out_index;
    logic [ENTRY_W-1:0] out_data;
    logic               out_last;

    modport master (output out_valid, out_index, out_data, out_last, input out_ready);
    modport slave  (input out_valid, out_index, out_data, out_last, output out_ready);
endinterface

// File: rtl/mem_tap_scan.sv
// mem_tap_scan: finds the lowest set mask bit at or above start (changed-entry scan).
// Latency: combinational. Backpressure: none; caller decides when to advance start.
// Ports: mask/start in; found, next_idx, is_last (no set bit above next_idx) out.
// Only built when MEM_SNAPSHOT_DIFF_EN is defined.
module mem_tap_scan import mem_tap_pkg::*; #(
    parameter int NUM_ENTRIES = DEF_NUM_ENTRIES,
    parameter int IDX_W       = $clog2(NUM_ENTRIES)
) (
    input  logic [NUM_ENTRIES-1:0] mask,
    input  logic [IDX_W:0]         start,
    output logic                   found,
    output logic [IDX_W-1:0]       next_idx,
    output logic                   is_last
);

    always_comb begin
        found    = 1'b0;
        next_idx = '0;
        is_last  = 1'b1;
        // Walk downward so the lowest qualifying index is the one left behind.
        for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
            if (mask[i] && (i >= int'(start))) begin
                found    = 1'b1;
                next_idx = IDX_W'(i);
            end
        end
        for (int j = 0; j < NUM_ENTRIES; j++) begin
            if (mask[j] && (j > int'(next_idx))) begin
                is_last = 1'b0;
            end
        end
    end

endmodule

// File: rtl/mem_snapshot_tap.sv
// mem_snapshot_tap: atomic snapshot of an N-entry array on trigger, streamed one entry per beat.
// Latency: trigger at cycle T gives first beat at T+2; full rate 1 beat/cycle thereafter.
// Backpressure: beat held stable while out_ready=0; triggers while busy are dropped and counted.
// Ports: clock, reset (async, active-high), tap_data, trigger, tap_out (master stream),
//        busy, drop_cnt (saturating), drop_clr.
// Build option MEM_SNAPSHOT_DIFF_EN: stream only entries that differ from the previous snapshot.
module mem_snapshot_tap import mem_tap_pkg::*; #(
    parameter int NUM_ENTRIES = DEF_NUM_ENTRIES,
    parameter int ENTRY_W     = DEF_ENTRY_W,
    parameter int IDX_W       = $clog2(NUM_ENTRIES),
    parameter int DROP_CNT_W  = DEF_DROP_CNT_W
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic [NUM_ENTRIES*ENTRY_W-1:0] tap_data,
    input  logic                           trigger,
    mem_snapshot_tap_if.master             tap_out,
    output logic                           busy,
    output logic [DROP_CNT_W-1:0]          drop_cnt,
    input  logic                           drop_clr
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ENTRIES - 1);

    tap_state_e         state_q, state_d;
    logic               valid_q, valid_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [ENTRY_W-1:0] data_q, data_d;
    logic               last_q, last_d;

    logic [ENTRY_W-1:0] live [NUM_ENTRIES];
    logic [ENTRY_W-1:0] snap [NUM_ENTRIES];
    logic               capture;

    for (genvar g = 0; g < NUM_ENTRIES; g++) begin : g_live
        assign live[g] = tap_data[entry_lsb(g, ENTRY_W) +: ENTRY_W];
    end

    // Latch on the trigger edge itself so the snapshot reflects the trigger cycle.
    assign capture = (state_q == TAP_IDLE) && trigger;
    assign busy    = (state_q != TAP_IDLE);

`ifdef MEM_SNAPSHOT_DIFF_EN
    logic [ENTRY_W-1:0]     prev [NUM_ENTRIES];
    logic [NUM_ENTRIES-1:0] mask;
    logic [IDX_W:0]         scan_start;
    logic                   scan_found;
    logic [IDX_W-1:0]       scan_idx;
    logic                   scan_last;

    for (genvar g = 0; g < NUM_ENTRIES; g++) begin : g_mask
        assign mask[g] = (snap[g] != prev[g]);
    end

    // CAPTURE searches from entry 0; STREAM searches just past the beat now leaving.
    assign scan_start = (state_q == TAP_STREAM) ? ({1'b0, idx_q} + (IDX_W+1)'(1)) : '0;

    mem_tap_scan #(.NUM_ENTRIES(NUM_ENTRIES), .IDX_W(IDX_W)) u_scan (
        .mask     (mask),
        .start    (scan_start),
        .found    (scan_found),
        .next_idx (scan_idx),
        .is_last  (scan_last)
    );
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                snap[i] <= '0;
`ifdef MEM_SNAPSHOT_DIFF_EN
                prev[i] <= '0;
`endif
            end
        end else if (capture) begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                snap[i] <= live[i];
`ifdef MEM_SNAPSHOT_DIFF_EN
                prev[i] <= snap[i];
`endif
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= TAP_IDLE;
            valid_q <= 1'b0;
            idx_q   <= '0;
            data_q  <= '0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            last_q  <= last_d;
        end
    end

    always_comb begin
        state_d = state_q;
        valid_d = valid_q;
        idx_d   = idx_q;
        data_d  = data_q;
        last_d  = last_q;
        case (state_q)
            TAP_IDLE: begin
                valid_d = 1'b0;
                last_d  = 1'b0;
                if (trigger) state_d = TAP_CAPTURE;
            end
            TAP_CAPTURE: begin
`ifdef MEM_SNAPSHOT_DIFF_EN
                if (scan_found) begin
                    state_d = TAP_STREAM;
                    valid_d = 1'b1;
                    idx_d   = scan_idx;
                    last_d  = scan_last;
                    data_d  = snap[scan_idx];
                end else begin
                    // Nothing changed: no beats, just a one-cycle out_last flag.
                    state_d = TAP_IDLE;
                    valid_d = 1'b0;
                    last_d  = 1'b1;
                end
`else
                state_d = TAP_STREAM;
                valid_d = 1'b1;
                idx_d   = '0;
                last_d  = 1'b0;
                data_d  = snap[0];
`endif
            end
            TAP_STREAM: begin
                if (valid_q && tap_out.out_ready) begin
                    if (last_q) begin
                        state_d = TAP_IDLE;
                        valid_d = 1'b0;
                        last_d  = 1'b0;
                    end else begin
`ifdef MEM_SNAPSHOT_DIFF_EN
                        idx_d  = scan_idx;
                        last_d = scan_last;
`else
                        // Stops at LAST_IDX, so unused indices of a non-power-of-two array are never reached.
                        idx_d  = idx_q + IDX_W'(1);
                        last_d = (idx_d == LAST_IDX);
`endif
                        data_d = snap[idx_d];
                    end
                end
            end
            default: begin
                state_d = TAP_IDLE;
                valid_d = 1'b0;
                last_d  = 1'b0;
            end
        endcase
    end

    // Clear beats a simultaneous dropped trigger.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            drop_cnt <= '0;
        end else if (drop_clr) begin
            drop_cnt <= '0;
        end else if (trigger && busy && (drop_cnt != '1)) begin
            drop_cnt <= drop_cnt + DROP_CNT_W'(1);
        end
    end

    assign tap_out.out_valid = valid_q;
    assign tap_out.out_index = idx_q;
    assign tap_out.out_data  = data_q;
    assign tap_out.out_last  = last_q;

endmodule

// File: tb/tb_mem_snapshot_tap.sv
// tb_mem_snapshot_tap: bench for mem_snapshot_tap (32x33 default instance plus a 5x8 instance).
// Expected beats come from a queue model built from the array contents at each accepted trigger.
module tb_mem_snapshot_tap;

    localparam int N  = 32;
    localparam int W  = 33;
    localparam int N5 = 5;
    localparam int W5 = 8;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    logic [N*W-1:0]   tap_data;
    logic [N5*W5-1:0] tap_data5;
    logic             trigger = 1'b0, drop_clr = 1'b0, busy;
    logic             trigger5 = 1'b0, drop_clr5 = 1'b0, busy5;
    logic [7:0]       drop_cnt, drop_cnt5;
    logic [W-1:0]     arr  [N];
    logic [W5-1:0]    arr5 [N5];
    logic [W-1:0]     prev  [N];
    logic [W5-1:0]    prev5 [N5];

    for (genvar g = 0; g < N; g++) begin : g_td
        assign tap_data[g*W +: W] = arr[g];
    end
    for (genvar g = 0; g < N5; g++) begin : g_td5
        assign tap_data5[g*W5 +: W5] = arr5[g];
    end

    mem_snapshot_tap_if #(.IDX_W(5), .ENTRY_W(W))  ifc ();
    mem_snapshot_tap_if #(.IDX_W(3), .ENTRY_W(W5)) ifc5 ();

    mem_snapshot_tap #(.NUM_ENTRIES(N), .ENTRY_W(W)) dut (
        .clock(clock), .reset(reset), .tap_data(tap_data), .trigger(trigger),
        .tap_out(ifc), .busy(busy), .drop_cnt(drop_cnt), .drop_clr(drop_clr)
    );

    mem_snapshot_tap #(.NUM_ENTRIES(N5), .ENTRY_W(W5)) dut5 (
        .clock(clock), .reset(reset), .tap_data(tap_data5), .trigger(trigger5),
        .tap_out(ifc5), .busy(busy5), .drop_cnt(drop_cnt5), .drop_clr(drop_clr5)
    );

    typedef struct {
        int           idx;
        logic [W-1:0] dat;
        bit           last;
    } beat_t;

    beat_t q[$];
    beat_t q5[$];
    int    xfer = 0, xfer5 = 0;
    int    n_chk = 0, n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Beats the snapshot of arr must produce, ascending index, last on the highest one.
    task automatic load_model();
        bit    sel [N];
        int    hi;
        beat_t b;
        hi = -1;
        for (int i = 0; i < N; i++) begin
`ifdef MEM_SNAPSHOT_DIFF_EN
            sel[i] = (arr[i] != prev[i]);
`else
            sel[i] = 1'b1;
`endif
            if (sel[i]) hi = i;
        end
        for (int i = 0; i < N; i++) begin
            if (sel[i]) begin
                b.idx = i; b.dat = arr[i]; b.last = (i == hi);
                q.push_back(b);
            end
            prev[i] = arr[i];
        end
    endtask

    task automatic load_model5();
        bit    sel [N5];
        int    hi;
        beat_t b;
        hi = -1;
        for (int i = 0; i < N5; i++) begin
`ifdef MEM_SNAPSHOT_DIFF_EN
            sel[i] = (arr5[i] != prev5[i]);
`else
            sel[i] = 1'b1;
`endif
            if (sel[i]) hi = i;
        end
        for (int i = 0; i < N5; i++) begin
            if (sel[i]) begin
                b.idx = i; b.dat = W'(arr5[i]); b.last = (i == hi);
                q5.push_back(b);
            end
            prev5[i] = arr5[i];
        end
    endtask

    int exp_n;

    // Trigger dut while it is idle; returns just after the capturing edge.
    task automatic start32();
        trigger = 1'b1;
        load_model();
        exp_n = q.size();
        tick();
        trigger = 1'b0;
    endtask

    task automatic wait_idle(input bit rnd, output int n);
        n = 0;
        while (busy && n < 500) begin
            tick();
            if (rnd) ifc.out_ready = 1'($urandom);
            n++;
        end
        chk("idle_timeout", 64'(busy), 0);
        ifc.out_ready = 1'b1;
    endtask

    // Stalled beats are compared again next cycle, so holds and skips both show up here.
    always @(negedge clock) begin
        if (!reset && ifc.out_valid) begin
            if (q.size() == 0) begin
                chk("beat_unexpected", 64'(ifc.out_valid), 0);
            end else begin
                chk("beat_index", 64'(ifc.out_index), 64'(q[0].idx));
                chk("beat_data",  64'(ifc.out_data),  64'(q[0].dat));
                chk("beat_last",  64'(ifc.out_last),  64'(q[0].last));
                if (ifc.out_ready) void'(q.pop_front());
            end
            if (ifc.out_ready) xfer++;
        end
    end

    always @(negedge clock) begin
        if (!reset && ifc5.out_valid) begin
            if (q5.size() == 0) begin
                chk("beat5_unexpected", 64'(ifc5.out_valid), 0);
            end else begin
                chk("beat5_index", 64'(ifc5.out_index), 64'(q5[0].idx));
                chk("beat5_data",  64'(ifc5.out_data),  64'(q5[0].dat));
                chk("beat5_last",  64'(ifc5.out_last),  64'(q5[0].last));
                if (ifc5.out_ready) void'(q5.pop_front());
            end
            if (ifc5.out_ready) xfer5++;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int n, x0, k;
        logic [4:0]   h_idx;
        logic [W-1:0] h_dat;

        for (int i = 0; i < N; i++)  begin arr[i] = '0;  prev[i] = '0;  end
        for (int i = 0; i < N5; i++) begin arr5[i] = '0; prev5[i] = '0; end
        ifc.out_ready  = 1'b1;
        ifc5.out_ready = 1'b1;

        // Reset state
        reset = 1'b1;
        repeat (3) tick();
        chk("rst_valid", 64'(ifc.out_valid), 0);
        chk("rst_index", 64'(ifc.out_index), 0);
        chk("rst_data",  64'(ifc.out_data),  0);
        chk("rst_last",  64'(ifc.out_last),  0);
        chk("rst_busy",  64'(busy),          0);
        chk("rst_drop",  64'(drop_cnt),      0);
        chk("rst5_valid", 64'(ifc5.out_valid), 0);
        chk("rst5_busy",  64'(busy5),          0);
        reset = 1'b0;
        tick();

        // Full stream at full rate, entry i = i + 0x100; array scrambled after the trigger edge
        for (int i = 0; i < N; i++) arr[i] = W'(i + 'h100);
        x0 = xfer;
        start32();
        for (int i = 0; i < N; i++) arr[i] = {1'($urandom), 32'($urandom)};
        chk("lat_busy_t1",  64'(busy),          1);
        chk("lat_valid_t1", 64'(ifc.out_valid), 0);
        tick();
        chk("lat_valid_t2", 64'(ifc.out_valid), 1);
        chk("lat_index_t2", 64'(ifc.out_index), 0);
        wait_idle(1'b0, n);
        chk("busy_low_cycle", 64'(n), 32);
        chk("t1_beats", 64'(xfer - x0), 32);
        chk("t1_q_empty", 64'(q.size()), 0);

        // Backpressure: ready 1,0,0,1 then random
        for (int i = 0; i < N; i++) arr[i] = {1'($urandom), 32'($urandom)};
        x0 = xfer;
        start32();
        tick();
        ifc.out_ready = 1'b1;
        tick();
        ifc.out_ready = 1'b0;
        h_idx = ifc.out_index;
        h_dat = ifc.out_data;
        tick();
        chk("hold_index_1", 64'(ifc.out_index), 64'(h_idx));
        chk("hold_data_1",  64'(ifc.out_data),  64'(h_dat));
        tick();
        ifc.out_ready = 1'b1;
        chk("hold_index_2", 64'(ifc.out_index), 64'(h_idx));
        wait_idle(1'b1, n);
        chk("bp_beats", 64'(xfer - x0), 32);
        chk("bp_q_empty", 64'(q.size()), 0);

        // Dropped triggers at T+5 and T+10, then clear with a simultaneous trigger
        for (int i = 0; i < N; i++) arr[i] = {1'($urandom), 32'($urandom)};
        start32();
        repeat (4) tick();
        trigger = 1'b1; tick(); trigger = 1'b0;
        repeat (4) tick();
        trigger = 1'b1; tick(); trigger = 1'b0;
        chk("drop_two", 64'(drop_cnt), 2);
        tick();
        drop_clr = 1'b1; trigger = 1'b1;
        tick();
        drop_clr = 1'b0; trigger = 1'b0;
        chk("drop_clr_wins", 64'(drop_cnt), 0);
        k = 0;
        while (!(ifc.out_valid && ifc.out_last) && k < 64) begin tick(); k++; end
        chk("last_beat_timeout", 64'(ifc.out_valid && ifc.out_last), 1);
        // Trigger in the cycle the last beat transfers is dropped
        trigger = 1'b1; tick(); trigger = 1'b0;
        chk("drop_on_last", 64'(drop_cnt), 1);
        chk("idle_after_last", 64'(busy), 0);
        // Trigger in the very next idle cycle is accepted
        x0 = xfer;
        start32();
        chk("retrigger_busy", 64'(busy), 1);
        wait_idle(1'b0, n);
        chk("retrigger_beats", 64'(xfer - x0), 32);

        // Reset mid-stream after 7 beats
        for (int i = 0; i < N; i++) arr[i] = {1'($urandom), 32'($urandom)};
        x0 = xfer;
        start32();
        k = 0;
        while ((xfer - x0) < 7 && k < 50) begin tick(); k++; end
        chk("seven_beats", 64'(xfer - x0), 7);
        reset = 1'b1;
        #1;
        chk("mid_rst_valid", 64'(ifc.out_valid), 0);
        chk("mid_rst_busy",  64'(busy),          0);
        chk("mid_rst_drop",  64'(drop_cnt),      0);
        q.delete();
        for (int i = 0; i < N; i++) prev[i] = '0;
        x0 = xfer;
        tick(); tick();
        reset = 1'b0;
        tick();
        chk("no_beats_after_rst", 64'(xfer - x0), 0);
        chk("after_rst_valid", 64'(ifc.out_valid), 0);
        for (int i = 0; i < N; i++) arr[i] = {1'($urandom), 32'($urandom)};
        x0 = xfer;
        start32();
        wait_idle(1'b1, n);
        chk("fresh_beats", 64'(xfer - x0), 64'(exp_n));

        // All-zero snapshot from reset, then change entries 3 and 17
        reset = 1'b1; tick(); reset = 1'b0;
        q.delete();
        for (int i = 0; i < N; i++) begin arr[i] = '0; prev[i] = '0; end
        tick();
        x0 = xfer;
        start32();
`ifdef MEM_SNAPSHOT_DIFF_EN
        tick();
        chk("empty_last_pulse", 64'(ifc.out_last),  1);
        chk("empty_no_valid",   64'(ifc.out_valid), 0);
        chk("empty_idle",       64'(busy),          0);
        tick();
        chk("empty_pulse_end",  64'(ifc.out_last),  0);
`endif
        wait_idle(1'b0, n);
        chk("zero_beats", 64'(xfer - x0), 64'(exp_n));
        arr[3]  = W'(32'h8000_0000 | $urandom);
        arr[17] = W'(32'h0000_0001 | $urandom);
        x0 = xfer;
        start32();
        wait_idle(1'b0, n);
        chk("delta_beats", 64'(xfer - x0), 64'(exp_n));

        // Non-power-of-two instance: indices 0..4 only
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < N5; i++) arr5[i] = W5'($urandom);
            x0 = xfer5;
            trigger5 = 1'b1;
            load_model5();
            exp_n = q5.size();
            tick();
            trigger5 = 1'b0;
            k = 0;
            while (busy5 && k < 100) begin
                tick();
                ifc5.out_ready = (r == 0) ? 1'b1 : 1'($urandom);
                k++;
            end
            ifc5.out_ready = 1'b1;
            chk("n5_idle_timeout", 64'(busy5), 0);
            chk("n5_beats", 64'(xfer5 - x0), 64'(exp_n));
            chk("n5_q_empty", 64'(q5.size()), 0);
            tick();
            chk("n5_no_extra", 64'(ifc5.out_valid), 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_snapshot_tap.md
Name: mem_snapshot_tap

Overview:
- Parametrised successor to the fixed 32-entry register-file debug tap.
- Captures an atomic snapshot of an N-entry array (live flattened view supplied by the insight wrapper) on a trigger.
- Streams the captured entries one per beat over a valid/ready port to the trace/debug fabric.
- Tracks dropped triggers and can stream only entries that changed since the previous snapshot.

Parameters:
- NUM_ENTRIES, 32, number of array entries tapped (2..256).
- ENTRY_W, 33, bits per entry.
- IDX_W, $clog2(NUM_ENTRIES), index width (derived; do not override).
- DROP_CNT_W, 8, width of the saturating dropped-trigger counter.

Ports:
- clock  in  1  block clock.
- reset  in  1  asynchronous, active-high reset.
- tap_data  in  NUM_ENTRIES*ENTRY_W  live array contents; entry i at bits [i*ENTRY_W +: ENTRY_W].
- trigger  in  1  single-cycle snapshot request.
- out_valid  out  1  beat available.
- out_ready  in  1  consumer accepts beat.
- out_index  out  IDX_W  entry index of the current beat.
- out_data  out  ENTRY_W  captured entry value.
- out_last  out  1  final beat of this snapshot.
- busy  out  1  snapshot capture or stream in progress.
- drop_cnt  out  DROP_CNT_W  triggers ignored while busy (saturating).
- drop_clr  in  1  clears drop_cnt.

Behaviour:
- Reset, asynchronous, active-high: state=IDLE; out_valid=0; out_index=0; out_data=0; out_last=0; busy=0; drop_cnt=0; snapshot storage=0.
- Reset asserted mid-stream aborts the stream immediately; no further beats; no partial completion.
- States: IDLE, CAPTURE, STREAM.
- IDLE: trigger=1 → CAPTURE. tap_data is latched into snapshot storage on that same clock edge, so the capture is atomic with respect to the trigger cycle.
- CAPTURE: one cycle. Loads the scan pointer with the first entry to send and goes to STREAM. busy=1 from this cycle onward.
- STREAM:
  - out_valid=1 with out_index, out_data and out_last registered.
  - out_data, out_index and out_last stay stable while out_valid=1 and out_ready=0.
  - A beat transfers when out_valid & out_ready. The next beat is presented on the following cycle, so full throughput is 1 beat/cycle.
  - out_last=1 on the beat with the final index to send. Transfer of that beat → IDLE, with out_valid=0 and busy=0 in the next cycle.
- Trigger latency: trigger at cycle T → first out_valid at T+2.
- Trigger while busy=1, including in the cycle the last beat transfers: the trigger is ignored and drop_cnt increments, saturating at all-ones.
- Trigger in IDLE in the cycle after the last transfer is accepted normally.
- drop_clr and a dropped trigger in the same cycle: the clear wins and drop_cnt=0.
- NUM_ENTRIES not a power of two: the scan pointer stops at NUM_ENTRIES-1 and never wraps into unused indices.

Optional Feature:
- Macro: MEM_SNAPSHOT_DIFF_EN.
- Defined:
  - A per-entry "changed" mask is computed as new capture != previous snapshot. The previous snapshot is held in a second storage bank, reset to 0.
  - STREAM sends only entries whose mask bit is set, in ascending index order. out_last marks the highest set index.
  - If no entries changed, CAPTURE goes directly to IDLE with no beats; a snapshot_empty pulse is OR-reduced into a one-cycle out_last with out_valid=0 (debug visibility only).
- Undefined: every entry 0..NUM_ENTRIES-1 is sent on every snapshot; no second bank or mask logic is built.

Decomposition:
- Package mem_tap_pkg:
  - state enum tap_state_e {TAP_IDLE, TAP_CAPTURE, TAP_STREAM}.
  - default parameter constants.
  - function to slice entry i from the flattened bus.
- Sub-module mem_tap_scan: a priority "next set index at or above pointer" finder over the mask.
  - Returns next_idx and is_last.
  - Instantiated only under MEM_SNAPSHOT_DIFF_EN.
  - In full mode the pointer simply increments.

Test Plan:
- Full mode, NUM_ENTRIES=32, entry i=i+0x100, trigger at T, out_ready=1 → beats at T+2..T+33, index 0..31, data 0x100..0x11F, out_last only on index 31; busy deasserts at T+34.
- Backpressure: out_ready toggled 1,0,0,1 → out_index/out_data held constant across stalled cycles; no beat skipped or duplicated.
- Trigger pulsed at T+5 and T+10 during a stream → both ignored, drop_cnt=2; drop_clr with a simultaneous trigger → drop_cnt=0.
- Reset asserted mid-stream after 7 beats → out_valid=0 immediately, busy=0, drop_cnt=0; a subsequent trigger streams a fresh 32 beats.
- MEM_SNAPSHOT_DIFF_EN: first snapshot of all-zero data → no beats; then change entries 3 and 17 and trigger → exactly 2 beats, index 3 then 17, out_last on 17.
- NUM_ENTRIES=5, ENTRY_W=8 → beats at index 0..4 only, out_last on index 4, no index 5..7 emitted.
